spi_display_receiver: RTL
=========================

# spi_display_receiver

Receive-side model of the 16-bit display SPI link driven by the stopwatch's SPI wrapper (Mosi/Cs/Clk_SPI, MAX7219-style address+data frames). It oversamples the three SPI lines in the system clock domain, assembles 16-bit frames, and commits each valid frame into a MAX7219-compatible register file: 8 digit registers plus the decode-mode, intensity, scan-limit, shutdown and display-test registers. It serves as the loopback checker on the second tile and as the front end of a future on-chip display driver.

## Interface

Parameters:
- SYNC_STAGES, 2: synchronizer flops per SPI input, minimum 2.

Ports:
- clk  input  1  system clock; the only clock in the block.
- res  input  1  reset; synchronous, active-high.
- Mosi  input  1  serial data, MSB first; asynchronous to clk.
- Cs  input  1  chip select, active low; asynchronous to clk.
- Clk_SPI  input  1  SPI clock, mode 0 (idle low, sample on rising edge); asynchronous to clk.
- digits  output  64  digit registers 0..7; digit n on bits [8n+7:8n].
- decode_mode  output  8  register 0x9.
- intensity  output  4  register 0xA, low nibble.
- scan_limit  output  3  register 0xB, low 3 bits.
- shutdown_n  output  1  register 0xC bit 0; 0 means shutdown.
- display_test  output  1  register 0xF bit 0.
- last_addr  output  4  address nibble (bits [11:8]) of the last valid frame.
- last_data  output  8  data byte of the last valid frame.
- frame_valid  output  1  one-cycle pulse when a valid frame is committed.
- frame_error  output  1  one-cycle pulse when a frame is dropped.

## Operation

- Each SPI input passes through SYNC_STAGES flops, then one more flop for edge detection. All logic below uses the synchronized values.
- States: IDLE (waiting for Cs low), SHIFT (Cs low, collecting bits), UNARMED (after reset, waiting for Cs high).
- After reset the block is in UNARMED. It moves to IDLE when synchronized Cs is high, which covers reset released mid-frame.
- IDLE -> SHIFT on a Cs falling edge. This clears the 16-bit shift register and the 5-bit bit counter.
- In SHIFT, each Clk_SPI rising edge shifts synchronized Mosi into bit 0 (left shift). The counter increments and saturates at 17.
- Clk_SPI edges are ignored in IDLE and UNARMED.
- SHIFT -> IDLE on a Cs rising edge:
  - Count = 16 gives a valid frame. Decode frame bits [11:8]: 0x1..0x8 write digit (addr-1); 0x9, 0xA, 0xB, 0xC and 0xF write their register; 0x0, 0xD and 0xE are no-ops.
  - On any valid frame, including a no-op, last_addr and last_data update and frame_valid pulses.
  - Bits [15:12] are don't-care.
  - Any other count (0..15, or ≥17) gives a dropped frame: frame_error pulses and no register changes.
- If a Clk_SPI rising edge and a Cs rising edge are detected in the same cycle, Cs wins: the bit is not shifted and not counted.
- Writes to the same register overwrite; the last frame wins.
- res asserted at any point returns all state to reset values on that clk edge, discarding any partial frame.
- Reset values:
  - digits = 0, decode_mode = 0, intensity = 0, scan_limit = 0.
  - shutdown_n = 0, display_test = 0.
  - last_addr = 0, last_data = 0.
  - frame_valid = 0, frame_error = 0.
  - State UNARMED.

## Timing

- Register outputs, last_addr/last_data and the pulses change on the (SYNC_STAGES+1)th clk rising edge after the first clk edge that samples raw Cs high. With the default this is 3 edges.
- frame_valid and frame_error are high for exactly one clk cycle and are never high together.
- A raw Mosi value must be stable from SYNC_STAGES+1 clk cycles before to 1 clk cycle after raw Clk_SPI rises.
- Clk_SPI high and low phases must each be ≥ SYNC_STAGES+2 clk cycles.
- Cs high between frames must be ≥ SYNC_STAGES+2 clk cycles.
- With the stopwatch's 1 MHz clk, the SPI clock must not exceed about 125 kHz.
- Back-to-back frames meeting the above are all committed; none are lost.

## Test plan

- Reset with Cs held low, then send a complete 16-bit frame 0x0305 -> no commit and no pulses (UNARMED); a following frame 0x0305 with Cs low after a high period -> digits[23:16] = 0x05, last_addr = 3, frame_valid pulses once.
- Frames 0x0C01, 0x0A0F, 0x0B07, 0x09FF -> shutdown_n = 1, intensity = 0xF, scan_limit = 7, decode_mode = 0xFF; digits unchanged at 0.
- A 15-bit frame and a 17-bit frame -> two frame_error pulses; all registers and last_addr/last_data unchanged.
- Eight frames 0x0100..0x0807 (data = n-1), then 0x0000 no-op -> digits = 0x0706050403020100, frame_valid pulses 9 times, last_addr = 0.
- Assert res for one cycle between bits 8 and 9 of frame 0x0F01 -> all outputs at reset values, no frame_valid or frame_error for that frame; the next clean frame 0x0F01 -> display_test = 1.
- Clk_SPI rising and Cs rising arranged to land on the same synchronized cycle after 16 bits -> the 17th edge is ignored, frame committed as valid.

Source files
------------

// File: rtl/spi_display_receiver.sv
// Receive side of the 16-bit MAX7219-style display SPI link: oversamples Mosi/Cs/Clk_SPI
// in the clk domain, assembles frames and commits them into the display register file.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_UNARMED | after reset, waiting for synchronized Cs high
// ST_IDLE    | waiting for a Cs falling edge
// ST_SHIFT   | Cs low, collecting bits on Clk_SPI rising edges
module spi_display_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic        Mosi,
  input  logic        Cs,
  input  logic        Clk_SPI,
  output logic [63:0] digits,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic [3:0]  last_addr,
  output logic [7:0]  last_data,
  output logic        frame_valid,
  output logic        frame_error
);

  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SHIFT   = 2'd2
  } state_t;

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] mosi_sync, cs_sync, sclk_sync;
  logic                   cs_d, sclk_d;
  logic                   mosi_s, cs_s, sclk_s;
  logic                   cs_rise, cs_fall, sclk_rise;

  // Only the low 12 bits of the frame are ever decoded; bits [15:12] shift out harmlessly.
  logic [11:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;

  logic start_frame, shift_bit, end_frame;

  always_ff @(posedge clk) begin
    if (res) begin
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_sync <= '0;
      cs_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], Mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], Cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], Clk_SPI};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign sclk_rise = sclk_s & ~sclk_d;

  always_ff @(posedge clk) begin
    if (res) begin
      state <= ST_UNARMED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNARMED: if (cs_s)    state_nxt = ST_IDLE;
      ST_IDLE:    if (cs_fall) state_nxt = ST_SHIFT;
      ST_SHIFT:   if (cs_rise) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_UNARMED;
    endcase
  end

  // A Cs rise in the same cycle as a Clk_SPI rise closes the frame without taking the bit.
  always_comb begin
    start_frame = 1'b0;
    shift_bit   = 1'b0;
    end_frame   = 1'b0;
    case (state)
      ST_IDLE:  start_frame = cs_fall;
      ST_SHIFT: begin
        end_frame = cs_rise;
        shift_bit = sclk_rise & ~cs_rise;
      end
      default: ;
    endcase
  end

  assign frame_addr = shift_reg[11:8];
  assign frame_data = shift_reg[7:0];

  always_ff @(posedge clk) begin
    if (res) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
      last_addr    <= '0;
      last_data    <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;

      if (start_frame) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_bit) begin
        shift_reg <= {shift_reg[10:0], mosi_s};
        if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end

      if (end_frame) begin
        if (bit_cnt == CNT_FULL) begin
          frame_valid <= 1'b1;
          last_addr   <= frame_addr;
          last_data   <= frame_data;
          for (int n = 0; n < 8; n++) begin
            if (frame_addr == 4'(n + 1)) begin
              digits[8*n +: 8] <= frame_data;
            end
          end
          case (frame_addr)
            4'h9:    decode_mode  <= frame_data;
            4'hA:    intensity    <= frame_data[3:0];
            4'hB:    scan_limit   <= frame_data[2:0];
            4'hC:    shutdown_n   <= frame_data[0];
            4'hF:    display_test <= frame_data[0];
            default: ;
          endcase
        end else begin
          frame_error <= 1'b1;
        end
      end
    end
  end

endmodule
